// File: rtl/uart_apb_tx_ctrl.sv
// APB master that configures a UART and feeds it bytes with status polling.
// Ports: CLK/RESET, IN_* byte handshake, APB master bus, CFG_DONE, TIMEOUT.
module uart_apb_tx_ctrl #(
   parameter logic [31:0] BAUD_DIV = 32'h0000_0020,
   parameter logic [31:0] CTRL_VAL = 32'h0000_0001,
   parameter logic [7:0]  POLL_MAX = 8'd16
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        IN_VALID,
   input  logic [7:0]  IN_DATA,
   output logic        IN_READY,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [9:0]  PADDR,
   output logic [31:0] PWDATA,
   input  logic [31:0] PRDATA,
   input  logic        PREADY,
   output logic        CFG_DONE,
   output logic        TIMEOUT
);

   typedef enum logic [2:0] {
      S_CFG_BAUD,
      S_CFG_CTRL,
      S_WAIT_IN,
      S_POLL,
      S_WRITE
   } state_t;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_ACCESS,
      PH_GAP
   } phase_t;

   state_t     state_q, state_d;
   state_t     tgt_q, tgt_d;
   phase_t     phase_q, phase_d;
   logic [7:0] byte_q, byte_d;
   logic [7:0] cnt_q, cnt_d;
   logic       cfg_done_q, cfg_done_d;
   logic       timeout_q, timeout_d;

   logic       unused_prdata;
   assign unused_prdata = ^PRDATA[31:1];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= S_CFG_BAUD;
         tgt_q      <= S_CFG_CTRL;
         phase_q    <= PH_IDLE;
         byte_q     <= 8'h00;
         cnt_q      <= 8'h00;
         cfg_done_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tgt_q      <= tgt_d;
         phase_q    <= phase_d;
         byte_q     <= byte_d;
         cnt_q      <= cnt_d;
         cfg_done_q <= cfg_done_d;
         timeout_q  <= timeout_d;
      end
   end

   // tgt_q holds the state to enter once the post-transfer gap is over
   always_comb begin
      state_d    = state_q;
      tgt_d      = tgt_q;
      phase_d    = phase_q;
      byte_d     = byte_q;
      cnt_d      = cnt_q;
      cfg_done_d = cfg_done_q;
      timeout_d  = timeout_q;
      if (state_q == S_WAIT_IN) begin
         if (IN_VALID && cfg_done_q) begin
            byte_d  = IN_DATA;
            cnt_d   = 8'h00;
            state_d = S_POLL;
            phase_d = PH_SETUP;
         end
      end else begin
         case (phase_q)
            PH_IDLE:   phase_d = PH_SETUP;
            PH_SETUP:  phase_d = PH_ACCESS;
            PH_ACCESS: begin
               if (PREADY) begin
                  phase_d = PH_GAP;
                  case (state_q)
                     S_CFG_BAUD: tgt_d = S_CFG_CTRL;
                     S_POLL: begin
                        if (!PRDATA[0]) begin
                           tgt_d = S_WRITE;
                        end else begin
                           if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                           if (cnt_d >= POLL_MAX) begin
                              timeout_d = 1'b1;
                              tgt_d     = S_WAIT_IN;
                           end else begin
                              tgt_d = S_POLL;
                           end
                        end
                     end
                     default:    tgt_d = S_WAIT_IN;
                  endcase
               end
            end
            default: begin
               state_d = tgt_q;
               if (tgt_q == S_WAIT_IN) begin
                  phase_d    = PH_IDLE;
                  cfg_done_d = 1'b1;
               end else begin
                  phase_d = PH_SETUP;
               end
            end
         endcase
      end
   end

   logic [9:0]  addr_sel;
   logic [31:0] data_sel;

   always_comb begin
      addr_sel = 10'd0;
      data_sel = 32'h0;
      case (state_q)
         S_CFG_BAUD: begin
            addr_sel = 10'd4;
            data_sel = BAUD_DIV;
         end
         S_CFG_CTRL: begin
            addr_sel = 10'd2;
            data_sel = CTRL_VAL;
         end
         S_POLL:  addr_sel = 10'd1;
         S_WRITE: data_sel = {24'h0, byte_q};
         default: ;
      endcase
   end

   assign PSEL     = (phase_q == PH_SETUP) || (phase_q == PH_ACCESS);
   assign PENABLE  = (phase_q == PH_ACCESS);
   assign PWRITE   = PSEL && (state_q != S_POLL);
   assign PADDR    = PSEL ? addr_sel : 10'd0;
   assign PWDATA   = PWRITE ? data_sel : 32'h0;
   assign IN_READY = (state_q == S_WAIT_IN) && cfg_done_q;
   assign CFG_DONE = cfg_done_q;
   assign TIMEOUT  = timeout_q;

endmodule

// File: tb/tb_uart_apb_tx_ctrl.sv
// Testbench for uart_apb_tx_ctrl: configuration table plus byte sequences.
// Ports: drives all DUT inputs and acts as APB slave / UART status model.
module tb_uart_apb_tx_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        psel, penable, pwrite;
   logic [9:0]  paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        cfg_done;
   logic        timeout;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_apb_tx_ctrl dut (
      .CLK      (clk),
      .RESET    (rst),
      .IN_VALID (in_valid),
      .IN_DATA  (in_data),
      .IN_READY (in_ready),
      .PSEL     (psel),
      .PENABLE  (penable),
      .PWRITE   (pwrite),
      .PADDR    (paddr),
      .PWDATA   (pwdata),
      .PRDATA   (prdata),
      .PREADY   (pready),
      .CFG_DONE (cfg_done),
      .TIMEOUT  (timeout)
   );

   typedef struct {
      logic        r;
      logic        rdy;
      logic [46:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic rdy, logic s, logic e,
                               logic w, logic [9:0] a, logic [31:0] d,
                               logic c, logic ir);
      vec_t v;
      v.r   = r;
      v.rdy = rdy;
      v.exp = {s, e, w, c, ir, a, d};
      return v;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   int          nreads, nwrites, ncyc;
   logic [31:0] wdata;
   logic        addr_bad;

   // present one byte, answer nfull STATUS reads as full, then empty
   task automatic send_byte(input logic [7:0] b, input int nfull);
      nreads   = 0;
      nwrites  = 0;
      ncyc     = 0;
      wdata    = 32'h0;
      addr_bad = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      #1;
      check("in_ready_before", {63'h0, in_ready}, 64'h1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = ~b;
      while (!in_ready && ncyc < 200) begin
         prdata = 32'h0;
         if (!psel && (paddr != 10'd0 || pwdata != 32'h0)) addr_bad = 1'b1;
         if (psel && penable) begin
            if (!pwrite) begin
               if (paddr != 10'd1) addr_bad = 1'b1;
               prdata = (nreads < nfull) ? 32'h1 : 32'h0;
               nreads++;
            end else begin
               if (paddr != 10'd0) addr_bad = 1'b1;
               nwrites++;
               wdata = pwdata;
            end
         end
         @(posedge clk);
         #1;
         ncyc++;
      end
      prdata = 32'h0;
      check("byte_bound", {63'h0, (ncyc >= 200)}, 64'h0);
      check("addr_ok", {63'h0, addr_bad}, 64'h0);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      prdata   = 32'h0;
      pready   = 1'b1;

      // clean configuration, CFG_DONE on cycle 7
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 1, 4, 32'h20, 0, 0));
      vecs.push_back(mk(0, 1, 1, 1, 1, 4, 32'h20, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 1, 2, 32'h01, 0, 0));
      vecs.push_back(mk(0, 1, 1, 1, 1, 2, 32'h01, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1));
      // reset from WAIT_IN, then BAUD access stalled 3 cycles
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 1, 4, 32'h20, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 1, 4, 32'h20, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 1, 4, 32'h20, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 1, 4, 32'h20, 0, 0));
      vecs.push_back(mk(0, 1, 1, 1, 1, 4, 32'h20, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 1, 2, 32'h01, 0, 0));
      vecs.push_back(mk(0, 1, 1, 1, 1, 2, 32'h01, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1));

      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         rst    = vecs[i].r;
         pready = vecs[i].rdy;
         #1;
         check($sformatf("vec%0d", i),
               {17'h0, psel, penable, pwrite, cfg_done, in_ready,
                paddr, pwdata},
               {17'h0, vecs[i].exp});
         @(posedge clk);
         #1;
      end
      pready = 1'b1;

      // empty status: one read, one write, 6 busy cycles
      send_byte(8'h53, 0);
      check("b53_reads", 64'(nreads), 64'd1);
      check("b53_writes", 64'(nwrites), 64'd1);
      check("b53_data", {32'h0, wdata}, 64'h53);
      check("b53_cycles", 64'(ncyc), 64'd6);
      check("b53_tmo", {63'h0, timeout}, 64'h0);

      // full twice then empty
      send_byte(8'hA5, 2);
      check("bA5_reads", 64'(nreads), 64'd3);
      check("bA5_writes", 64'(nwrites), 64'd1);
      check("bA5_data", {32'h0, wdata}, 64'hA5);
      check("bA5_tmo", {63'h0, timeout}, 64'h0);

      // always full: abandoned after 16 polls
      send_byte(8'h77, 1000);
      check("b77_reads", 64'(nreads), 64'd16);
      check("b77_writes", 64'(nwrites), 64'd0);
      check("b77_tmo", {63'h0, timeout}, 64'h1);

      // sticky timeout through a good byte
      send_byte(8'h3C, 0);
      check("b3C_writes", 64'(nwrites), 64'd1);
      check("b3C_data", {32'h0, wdata}, 64'h3C);
      check("b3C_tmo", {63'h0, timeout}, 64'h1);

      // reset during WRITE access
      in_valid = 1'b1;
      in_data  = 8'h99;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      ncyc = 0;
      while (!(psel && penable && pwrite) && ncyc < 50) begin
         @(posedge clk);
         #1;
         ncyc++;
      end
      check("wr_reached", {63'h0, (ncyc >= 50)}, 64'h0);
      check("wr_paddr", {54'h0, paddr}, 64'h0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_psel", {63'h0, psel}, 64'h0);
      check("rst_done", {63'h0, cfg_done}, 64'h0);
      check("rst_tmo", {63'h0, timeout}, 64'h0);
      rst = 1'b0;
      ncyc  = 0;
      wdata = 32'h0;
      while (!cfg_done && ncyc < 20) begin
         if (psel && penable && pwrite && paddr == 10'd4) wdata = pwdata;
         @(posedge clk);
         #1;
         ncyc++;
      end
      check("recfg_cycles", 64'(ncyc), 64'd7);
      check("recfg_baud", {32'h0, wdata}, 64'h20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_apb_tx_ctrl.md
UART_APB_TX_CTRL -- requirements
Module: uart_apb_tx_ctrl

Interface
REQ-001 Parameter BAUD_DIV, default 32'h0000_0020: value written to the UART baud register during configuration.
REQ-002 Parameter CTRL_VAL, default 32'h0000_0001: value written to the UART control register (TX enable) during configuration.
REQ-003 Parameter POLL_MAX, default 8'd16: maximum consecutive status polls per byte before it is abandoned.
REQ-004 CLK  input  1  single clock; all logic on posedge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 IN_VALID  input  1  requester has a byte on IN_DATA.
REQ-007 IN_DATA  input  8  byte to transmit.
REQ-008 IN_READY  output  1  byte accepted this cycle when IN_VALID=1.
REQ-009 PSEL, PENABLE, PWRITE  output  1 each  APB master controls.
REQ-010 PADDR  output  10  APB word address, bits [11:2].
REQ-011 PWDATA  output  32  APB write data.
REQ-012 PRDATA  input  32  APB read data.
REQ-013 PREADY  input  1  APB slave ready.
REQ-014 CFG_DONE  output  1  configuration complete, level.
REQ-015 TIMEOUT  output  1  sticky: at least one byte abandoned after POLL_MAX polls.

Function
REQ-016 Register map (word address): DATA=0, STATUS=1 (bit0 = TX full), CTRL=2, BAUD=4.
REQ-017 Every APB transfer: one setup cycle (PSEL=1, PENABLE=0), then access cycles (PSEL=1, PENABLE=1) held with PADDR/PWRITE/PWDATA stable until PREADY=1.
REQ-018 After each completed transfer, one idle cycle (PSEL=0, PENABLE=0) precedes the next transfer.
REQ-019 States: CFG_BAUD, CFG_CTRL, WAIT_IN, POLL, WRITE, each transfer state with setup/access/gap sub-phases.
REQ-020 After reset: one idle cycle, then write BAUD_DIV to BAUD, gap, write CTRL_VAL to CTRL, gap, enter WAIT_IN with CFG_DONE=1.
REQ-021 IN_READY is 1 only in WAIT_IN with CFG_DONE=1, combinationally; on IN_VALID&IN_READY, IN_DATA is captured, the poll counter is cleared, and the block enters POLL next cycle.
REQ-022 POLL: read STATUS (PWRITE=0, PWDATA=0); sample PRDATA[0] on the access cycle with PREADY=1.
REQ-023 PRDATA[0]=0 -> gap then WRITE; PRDATA[0]=1 -> increment poll counter, gap, repeat POLL.
REQ-024 When a poll returns full and poll count reaches POLL_MAX, the byte is dropped, TIMEOUT set to 1, gap, return to WAIT_IN.
REQ-025 WRITE: write {24'h0, captured byte} to DATA; after completion, gap, return to WAIT_IN.
REQ-026 No new byte is accepted while POLL or WRITE is in progress; IN_DATA changes after capture have no effect.
REQ-027 Poll counter is 8 bits, saturating, never wraps.
REQ-028 PREADY low indefinitely stalls the block in the access cycle; no internal timeout on PREADY.
REQ-029 PADDR and PWDATA are 0 whenever PSEL=0.

Reset
REQ-030 RESET=1 at any posedge, including mid-transfer, forces next cycle: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, IN_READY=0, CFG_DONE=0, TIMEOUT=0, poll counter=0, captured byte=0, state=CFG_BAUD idle phase.
REQ-031 After RESET deasserts, full configuration (REQ-020) is repeated; any in-flight byte is lost.

Verification
REQ-032 Reset release, PREADY=1 always -> BAUD write (PADDR=4, PWDATA=0x20), idle, CTRL write (PADDR=2, PWDATA=0x01), idle, CFG_DONE=1 on cycle 7 after reset release.
REQ-033 PREADY low 3 cycles during BAUD access -> PENABLE=1 held 4 cycles, address/data stable, sequence then continues.
REQ-034 IN_DATA=0x53, STATUS returns 0 -> one read at PADDR=1, idle, write PADDR=0 PWDATA=0x53, IN_READY back to 1 after gap.
REQ-035 STATUS returns full 2 times then empty, IN_DATA=0xA5 -> exactly 3 reads, then one write of 0xA5; TIMEOUT stays 0.
REQ-036 STATUS always full, POLL_MAX=16 -> 16 reads, no DATA write, TIMEOUT=1 and remains 1 through a following successful byte.
REQ-037 RESET asserted during WRITE access -> PSEL=0 next cycle, CFG_DONE=0, TIMEOUT=0, full reconfiguration follows.
